// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, the bundle of delayable decode signals,
// and the sync polarity helper.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic display_on;
    logic line_start;
    logic frame_start;
  } timing_sig_t;

  // Maps a logical "sync active" onto the pin level.
  function automatic logic sync_level(input logic active, input logic neg);
    return active ^ neg;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// N-stage shift register with a per-bit reset value; N=0 is a pass-through.
// Stages shift on every clock edge so the lag is fixed in cycles.
module vga_sync_delay #(
  parameter int             N       = 0,
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (N == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = &{1'b0, clk, rst_n};
      assign q = d;
    end else begin : g_pipe
      logic [W-1:0] stage_reg [N];
      for (genvar gi = 0; gi < N; gi++) begin : g_stage
        logic [W-1:0] prev;
        if (gi == 0) begin : g_first
          assign prev = d;
        end else begin : g_rest
          assign prev = stage_reg[gi-1];
        end
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) stage_reg[gi] <= RST_VAL;
          else        stage_reg[gi] <= prev;
        end
      end
      assign q = stage_reg[N-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel/line counters, registered sync/enable
// decodes, line/frame strobes and a free-running frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = H_VISIBLE_DEF,
  parameter int H_FRONT    = H_FRONT_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BACK     = H_BACK_DEF,
  parameter int V_VISIBLE  = V_VISIBLE_DEF,
  parameter int V_FRONT    = V_FRONT_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BACK     = V_BACK_DEF,
  parameter int SYNC_NEG   = 1,
  parameter int SYNC_DELAY = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  output logic [CNT_W-1:0] hpos,
  output logic [CNT_W-1:0] vpos,
  output logic             hsync,
  output logic             vsync,
  output logic             display_on,
  output logic             line_start,
  output logic             frame_start,
  output logic [7:0]       frame_cnt
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic             NEG      = (SYNC_NEG != 0);

  // Reset state decodes exactly as (H_LAST, V_LAST) would: blanked, sync inactive.
  localparam timing_sig_t SIG_RST = '{hsync: NEG, vsync: NEG, display_on: 1'b0,
                                      line_start: 1'b0, frame_start: 1'b0};

  logic [CNT_W-1:0] hpos_reg, hpos_next;
  logic [CNT_W-1:0] vpos_reg, vpos_next;
  logic [7:0]       frame_cnt_reg, frame_cnt_next;
  timing_sig_t      sig_reg, sig_next, sig_delayed;

  always_comb begin
    hpos_next      = hpos_reg;
    vpos_next      = vpos_reg;
    frame_cnt_next = frame_cnt_reg;
    if (ena) begin
      if (hpos_reg == H_LAST) begin
        hpos_next = '0;
        if (vpos_reg == V_LAST) begin
          vpos_next      = '0;
          frame_cnt_next = frame_cnt_reg + 8'd1;
        end else begin
          vpos_next = vpos_reg + 1'b1;
        end
      end else begin
        hpos_next = hpos_reg + 1'b1;
      end
    end
  end

  // Decoding the next value keeps sig_reg coincident with hpos/vpos.
  always_comb begin
    sig_next             = SIG_RST;
    sig_next.hsync       = sync_level((hpos_next >= HS_START) && (hpos_next < HS_END), NEG);
    sig_next.vsync       = sync_level((vpos_next >= VS_START) && (vpos_next < VS_END), NEG);
    sig_next.display_on  = (hpos_next < H_VIS) && (vpos_next < V_VIS);
    sig_next.line_start  = ena && (hpos_next == '0);
    sig_next.frame_start = ena && (hpos_next == '0) && (vpos_next == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_reg      <= H_LAST;
      vpos_reg      <= V_LAST;
      frame_cnt_reg <= 8'hFF;
      sig_reg       <= SIG_RST;
    end else begin
      hpos_reg      <= hpos_next;
      vpos_reg      <= vpos_next;
      frame_cnt_reg <= frame_cnt_next;
      sig_reg       <= sig_next;
    end
  end

  vga_sync_delay #(
    .N       (SYNC_DELAY),
    .W       ($bits(timing_sig_t)),
    .RST_VAL (SIG_RST)
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sig_reg),
    .q     (sig_delayed)
  );

  assign hpos        = hpos_reg;
  assign vpos        = vpos_reg;
  assign frame_cnt   = frame_cnt_reg;
  assign hsync       = sig_delayed.hsync;
  assign vsync       = sig_delayed.vsync;
  assign display_on  = sig_delayed.display_on;
  assign line_start  = sig_delayed.line_start;
  assign frame_start = sig_delayed.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: stimulus queues expected values tagged with a cycle number,
// a monitor on the falling edge pops and compares them against three DUT instances.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // a: default timing; s: tiny timing, positive sync; d: default timing, SYNC_DELAY=2
  logic       rst_a = 1'b0, rst_s = 1'b0, rst_d = 1'b0;
  logic       ena_a = 1'b1, ena_s = 1'b1, ena_d = 1'b1;
  logic [9:0] hp_a, vp_a, hp_s, vp_s, hp_d, vp_d;
  logic       hs_a, vs_a, don_a, ls_a, fs_a;
  logic       hs_s, vs_s, don_s, ls_s, fs_s;
  logic       hs_d, vs_d, don_d, ls_d, fs_d;
  logic [7:0] fc_a, fc_s, fc_d;

  vga_timing_gen u_a (
    .clk(clk), .rst_n(rst_a), .ena(ena_a), .hpos(hp_a), .vpos(vp_a),
    .hsync(hs_a), .vsync(vs_a), .display_on(don_a), .line_start(ls_a),
    .frame_start(fs_a), .frame_cnt(fc_a)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_NEG(0), .SYNC_DELAY(0)
  ) u_s (
    .clk(clk), .rst_n(rst_s), .ena(ena_s), .hpos(hp_s), .vpos(vp_s),
    .hsync(hs_s), .vsync(vs_s), .display_on(don_s), .line_start(ls_s),
    .frame_start(fs_s), .frame_cnt(fc_s)
  );

  vga_timing_gen #(.SYNC_DELAY(2)) u_d (
    .clk(clk), .rst_n(rst_d), .ena(ena_d), .hpos(hp_d), .vpos(vp_d),
    .hsync(hs_d), .vsync(vs_d), .display_on(don_d), .line_start(ls_d),
    .frame_start(fs_d), .frame_cnt(fc_d)
  );

  localparam int A = 0, S = 8, D = 16;
  localparam int HP = 0, VP = 1, HS = 2, VS = 3, DON = 4, LS = 5, FS = 6, FC = 7;

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string name;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic int get_sig(input int id);
    case (id)
      A+HP: return int'(hp_a);  A+VP: return int'(vp_a);
      A+HS: return int'(hs_a);  A+VS: return int'(vs_a);
      A+DON: return int'(don_a); A+LS: return int'(ls_a);
      A+FS: return int'(fs_a);  A+FC: return int'(fc_a);
      S+HP: return int'(hp_s);  S+VP: return int'(vp_s);
      S+HS: return int'(hs_s);  S+VS: return int'(vs_s);
      S+DON: return int'(don_s); S+LS: return int'(ls_s);
      S+FS: return int'(fs_s);  S+FC: return int'(fc_s);
      D+HP: return int'(hp_d);  D+VP: return int'(vp_d);
      D+HS: return int'(hs_d);  D+VS: return int'(vs_d);
      D+DON: return int'(don_d); D+LS: return int'(ls_d);
      D+FS: return int'(fs_d);  D+FC: return int'(fc_d);
      default: return -1;
    endcase
  endfunction

  task automatic chk(input int id, input int val, input string nm);
    exp_t e;
    e.cyc = cyc; e.sig = id; e.val = val; e.name = nm;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input int base, input int sync_idle, input string nm);
    chk(base+HP, 799, {nm, "_rst_hpos"});
    chk(base+VP, 524, {nm, "_rst_vpos"});
    chk(base+HS, sync_idle, {nm, "_rst_hsync"});
    chk(base+VS, sync_idle, {nm, "_rst_vsync"});
    chk(base+DON, 0, {nm, "_rst_don"});
    chk(base+LS, 0, {nm, "_rst_ls"});
    chk(base+FS, 0, {nm, "_rst_fs"});
    chk(base+FC, 255, {nm, "_rst_fcnt"});
  endtask

  // Monitor: every cycle, compare everything the stimulus expects for that cycle.
  initial begin
    exp_t e;
    int   got;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e   = q.pop_front();
        got = get_sig(e.sig);
        n_vec++;
        if (e.cyc != cyc || got != e.val) begin
          n_miss++;
          $display("FAIL %s cyc=%0d (queued for %0d) got=%0d expected=%0d",
                   e.name, cyc, e.cyc, got, e.val);
        end
      end
    end
  end

  initial begin
    // Reset state on all instances (u_s uses positive sync, so idle level 0).
    tick(); tick();
    chk_reset(A, 1, "a");
    chk_reset(D, 1, "d");
    chk(S+HS, 0, "s_rst_hsync");
    chk(S+FC, 255, "s_rst_fcnt");

    // First enabled cycle wraps to (0,0).
    rst_a = 1'b1;
    tick();
    chk(A+HP, 0, "a_first_hpos");  chk(A+VP, 0, "a_first_vpos");
    chk(A+FS, 1, "a_first_fs");    chk(A+LS, 1, "a_first_ls");
    chk(A+DON, 1, "a_first_don");  chk(A+FC, 0, "a_first_fcnt");
    chk(A+HS, 1, "a_first_hsync");

    // One full line: hsync low on 656..751, display on 0..639.
    for (int h = 1; h < 800; h++) begin
      tick();
      chk(A+HP, h, "a_line_hpos");
      chk(A+HS, (h >= 656 && h < 752) ? 0 : 1, "a_line_hsync");
      chk(A+DON, (h < 640) ? 1 : 0, "a_line_don");
      chk(A+LS, 0, "a_line_ls");
    end
    tick();
    chk(A+HP, 0, "a_wrap_hpos"); chk(A+VP, 1, "a_wrap_vpos");
    chk(A+LS, 1, "a_wrap_ls");   chk(A+FS, 0, "a_wrap_fs");

    // Enable hold at hpos==0: frozen counters, no stretched strobe.
    ena_a = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk(A+HP, 0, "a_hold_hpos"); chk(A+VP, 1, "a_hold_vpos");
      chk(A+LS, 0, "a_hold_ls");
    end
    ena_a = 1'b1;
    tick();
    chk(A+HP, 1, "a_resume_hpos"); chk(A+VP, 1, "a_resume_vpos");
    chk(A+LS, 0, "a_resume_ls");

    // Tiny timing: H 8/2/3/2 (15), V 4/1/2/1 (8), positive sync; 3 full frames.
    rst_s = 1'b1;
    for (int f = 0; f < 3; f++)
      for (int v = 0; v < 8; v++)
        for (int h = 0; h < 15; h++) begin
          tick();
          chk(S+HP, h, "s_hpos"); chk(S+VP, v, "s_vpos");
          chk(S+HS, (h >= 10 && h < 13) ? 1 : 0, "s_hsync");
          chk(S+VS, (v >= 5 && v < 7) ? 1 : 0, "s_vsync");
          chk(S+DON, (h < 8 && v < 4) ? 1 : 0, "s_don");
          chk(S+LS, (h == 0) ? 1 : 0, "s_ls");
          chk(S+FS, (h == 0 && v == 0) ? 1 : 0, "s_fs");
          chk(S+FC, f, "s_fcnt");
        end
    // Keep going past 256 frames to see frame_cnt wrap.
    for (int f = 3; f <= 256; f++) begin
      tick();
      chk(S+FS, 1, "s_long_fs");
      chk(S+FC, f % 256, "s_long_fcnt");
      repeat (119) tick();
    end

    // SYNC_DELAY=2: strobes/decodes lag hpos by two cycles.
    rst_d = 1'b1;
    for (int h = 0; h < 300; h++) begin
      tick();
      chk(D+HP, h, "d_hpos");
      chk(D+DON, (h >= 2) ? 1 : 0, "d_don");
      chk(D+LS, (h == 2) ? 1 : 0, "d_ls");
      chk(D+FS, (h == 2) ? 1 : 0, "d_fs");
      chk(D+HS, 1, "d_hsync_idle");
      chk(D+FC, 0, "d_fcnt");
    end
    // At hpos==300, drop reset between edges: outputs must return immediately.
    tick();
    rst_d = 1'b0;
    #1;
    chk_reset(D, 1, "d_async");
    tick();
    rst_d = 1'b1;
    for (int h = 0; h <= 760; h++) begin
      tick();
      chk(D+HP, h, "d2_hpos");
      chk(D+HS, (h >= 658 && h < 754) ? 0 : 1, "d2_hsync");
      chk(D+DON, (h >= 2 && h < 642) ? 1 : 0, "d2_don");
    end

    tick(); tick();
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL drain %0d expectations left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
